dmem_responder: RTL and testbench

//  Memory-side responder for the core's MEM-stage load/store port: accepts one

---
 rtl/rv_mem_pkg.sv | 30 +++
 rtl/dmem_lane_align.sv | 51 +++++
 rtl/dmem_responder.sv | 199 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared encodings for the MEM-stage load/store port: access sizes and the
// responder's state machine states.
package rv_mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // High when the size code is illegal or the low address bits misalign it.
  function automatic logic size_addr_bad(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
// Purely combinational; the caller guarantees the access is aligned.
module dmem_lane_align
  import rv_mem_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic [1:0]             addr,
  input  logic [1:0]             size,
  input  logic                   sign,
  input  logic [WORD_SIZE-1:0]   wdata,
  input  logic [WORD_SIZE-1:0]   rword,
  output logic [WORD_SIZE/8-1:0] byte_en,
  output logic [WORD_SIZE-1:0]   wdata_shifted,
  output logic [WORD_SIZE-1:0]   rdata_ext
);

  localparam int unsigned NB = WORD_SIZE / 8;

  logic [4:0]           shamt_s;
  logic [WORD_SIZE-1:0] rshift_s;

  assign shamt_s       = {addr, 3'b000};
  assign rshift_s      = rword >> shamt_s;
  assign wdata_shifted = wdata << shamt_s;

  // Lane enables and load extension by access size.
  always_comb begin
    byte_en   = '0;
    rdata_ext = '0;
    case (size)
      SIZE_BYTE: begin
        byte_en   = {{(NB-1){1'b0}}, 1'b1} << addr;
        rdata_ext = {{(WORD_SIZE-8){sign & rshift_s[7]}}, rshift_s[7:0]};
      end
      SIZE_HALF: begin
        byte_en   = {{(NB-2){1'b0}}, 2'b11} << {addr[1], 1'b0};
        rdata_ext = {{(WORD_SIZE-16){sign & rshift_s[15]}}, rshift_s[15:0]};
      end
      SIZE_WORD: begin
        byte_en   = '1;
        rdata_ext = rshift_s;
      end
      default: begin
        byte_en   = '0;
        rdata_ext = '0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the MEM-stage load/store port: one request per
// handshake, optional wait states, byte-lane stores and extended loads.
module dmem_responder
  import rv_mem_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int NUM_WORDS = 1024,
  parameter int ADDR_SIZE = $clog2(NUM_WORDS),
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [1:0]           data_size,
  input  logic                 data_sign,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WORD_SIZE-1:0] resp_rdata,
  output logic                 resp_err
);

  localparam logic [3:0]           LAT_M1  = 4'(LATENCY - 1);
  localparam logic [WORD_SIZE-3:0] WORDS_W = (WORD_SIZE-2)'(NUM_WORDS);

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_SIZE+1:0]   addr_q, addr_d;
  logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
  logic                   rd_q, rd_d, wr_q, wr_d;
  logic [1:0]             size_q, size_d;
  logic                   sign_q, sign_d;
  logic                   req_ready_q, req_ready_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   resp_err_q, resp_err_d;
  logic [WORD_SIZE-1:0]   resp_rdata_q, resp_rdata_d;

  logic [WORD_SIZE-1:0]   mem_q [NUM_WORDS];

  logic                   accept_s, req_err_s, in_idle_s, do_access_s;
  logic [ADDR_SIZE+1:0]   acc_addr_s;
  logic [WORD_SIZE-1:0]   acc_wdata_s;
  logic                   acc_rd_s, acc_wr_s, acc_sign_s;
  logic [1:0]             acc_size_s;
  logic [WORD_SIZE/8-1:0] byte_en_s;
  logic [WORD_SIZE-1:0]   wdata_sh_s, rdata_ext_s, rword_s;

  assign accept_s  = req_valid && req_ready_q;
  assign req_err_s = (mem_read == mem_write)
                   || size_addr_bad(data_size, req_addr[1:0])
                   || (req_addr[WORD_SIZE-1:2] >= WORDS_W);

  // With zero wait states the access happens on the accept edge, straight from the inputs.
  assign in_idle_s   = (state_q == ST_IDLE);
  assign acc_addr_s  = in_idle_s ? req_addr[ADDR_SIZE+1:0] : addr_q;
  assign acc_wdata_s = in_idle_s ? req_wdata : wdata_q;
  assign acc_rd_s    = in_idle_s ? mem_read  : rd_q;
  assign acc_wr_s    = in_idle_s ? mem_write : wr_q;
  assign acc_size_s  = in_idle_s ? data_size : size_q;
  assign acc_sign_s  = in_idle_s ? data_sign : sign_q;
  assign rword_s     = mem_q[acc_addr_s[ADDR_SIZE+1:2]];

  dmem_lane_align #(.WORD_SIZE(WORD_SIZE)) u_align (
    .addr          (acc_addr_s[1:0]),
    .size          (acc_size_s),
    .sign          (acc_sign_s),
    .wdata         (acc_wdata_s),
    .rword         (rword_s),
    .byte_en       (byte_en_s),
    .wdata_shifted (wdata_sh_s),
    .rdata_ext     (rdata_ext_s)
  );

  // Next-state, capture and response logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    size_d       = size_q;
    sign_d       = sign_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    do_access_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          addr_d      = req_addr[ADDR_SIZE+1:0];
          wdata_d     = req_wdata;
          rd_d        = mem_read;
          wr_d        = mem_write;
          size_d      = data_size;
          sign_d      = data_sign;
          req_ready_d = 1'b0;
          if (req_err_s) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (LATENCY == 0) begin
            do_access_s  = 1'b1;
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = acc_rd_s ? rdata_ext_s : '0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = LAT_M1;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          do_access_s  = 1'b1;
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = acc_rd_s ? rdata_ext_s : '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          req_ready_d  = 1'b1;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
    endcase
  end

  // State, captured request and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      size_q       <= 2'b00;
      sign_q       <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      sign_q       <= sign_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Storage array: not cleared by reset; a store racing a reset is dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WORD_SIZE/8; i++) begin
      if (!rst && do_access_s && acc_wr_s && byte_en_s[i]) begin
        mem_q[acc_addr_s[ADDR_SIZE+1:2]][8*i +: 8] <= wdata_sh_s[8*i +: 8];
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=2, 1024 words).
module tb_dmem_responder;
  localparam int LAT = 2;
  localparam int NW  = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, mem_read, mem_write, data_sign;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [1:0]  data_size;
  logic        resp_valid, resp_ready, resp_err;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.WORD_SIZE(32), .NUM_WORDS(NW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .data_size(data_size), .data_sign(data_sign),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; mem_read = rd; mem_write = wr;
    data_size = sz;   data_sign = sg; req_addr = a; req_wdata = wd;
  endtask

  // Called at a negedge; returns at the negedge right after the response handshake.
  task automatic xact(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                      input logic sg, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    int exp_lat;
    exp_lat = exp_err ? 1 : ((LAT == 0) ? 1 : LAT + 1);
    chk({tag, ".rdy"}, {31'd0, req_ready}, 32'd1);
    drive(rd, wr, sz, sg, a, wd);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, n, exp_lat);
    chk({tag, ".err"}, {31'd0, resp_err}, {31'd0, exp_err});
    chk({tag, ".data"}, resp_rdata, exp_rdata);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, ".done"}, {30'd0, resp_valid, req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    int n;
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst.rdy",   {31'd0, req_ready},  32'd1);
    chk("rst.valid", {31'd0, resp_valid}, 32'd0);
    chk("rst.data",  resp_rdata,          32'd0);
    chk("rst.err",   {31'd0, resp_err},   32'd0);

    xact("sw10",  1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("lw10",  1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    xact("sb13",  1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h12345680, 32'h0, 1'b0);
    xact("lb13",  1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
    xact("lbu13", 1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h00000080, 1'b0);
    xact("lw10b", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
    xact("sh12",  1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD1234, 32'h0, 1'b0);
    xact("lw10c", 1'b1, 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'h1234BEEF, 1'b0);
    xact("lh10",  1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
    xact("lhu10", 1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
    xact("lh12",  1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h00001234, 1'b0);
    xact("lb11",  1'b1, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'hFFFFFFBE, 1'b0);

    xact("e.lh11",  1'b1, 1'b0, 2'b01, 1'b1, 32'h11, 32'h0, 32'h0, 1'b1);
    xact("e.lw12",  1'b1, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
    xact("e.size",  1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
    xact("e.range", 1'b1, 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1);
    xact("e.rdwr",  1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h11111111, 32'h0, 1'b1);
    xact("e.none",  1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h22222222, 32'h0, 1'b1);
    xact("e.sw12",  1'b0, 1'b1, 2'b10, 1'b0, 32'h12, 32'h33333333, 32'h0, 1'b1);
    xact("e.sh13",  1'b0, 1'b1, 2'b01, 1'b0, 32'h13, 32'h44444444, 32'h0, 1'b1);
    xact("e.swrng", 1'b0, 1'b1, 2'b10, 1'b0, 32'h1010, 32'h55555555, 32'h0, 1'b1);
    xact("e.after", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0);

    xact("swlast", 1'b0, 1'b1, 2'b10, 1'b0, 32'hFFC, 32'h0BADF00D, 32'h0, 1'b0);
    xact("lwlast", 1'b1, 1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, 32'h0BADF00D, 1'b0);

    // Backpressure: hold resp_ready low while a second request waits.
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0);
    n = 1;
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp.lat", n, LAT + 1);
    held = resp_rdata;
    chk("bp.data", held, 32'h1234BEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.hold.valid", {31'd0, resp_valid}, 32'd1);
      chk("bp.hold.data",  resp_rdata, 32'h1234BEEF);
      chk("bp.hold.rdy",   {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("bp.hs.valid", {31'd0, resp_valid}, 32'd0);
    chk("bp.hs.rdy",   {31'd0, req_ready},  32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp.acc.rdy", {31'd0, req_ready}, 32'd0);
    n = 1;
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp2.lat",  n, LAT + 1);
    chk("bp2.data", resp_rdata, 32'h0BADF00D);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // Reset during WAIT drops the pending store.
    xact("sw20", 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h5A5A5A5A, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("mid.rdy",   {31'd0, req_ready},  32'd1);
    chk("mid.valid", {31'd0, resp_valid}, 32'd0);
    repeat (4) @(negedge clk);
    chk("mid.idle",  {31'd0, resp_valid}, 32'd0);
    xact("mid.lw20", 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h5A5A5A5A, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
